// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the constants that size the default
// scoreboarded register file.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  // Default number of in-flight writes tracked per architectural register.
  localparam int REGFILE_PEND_MAX = 3;

  // Pending-write counter wide enough to hold 0..REGFILE_PEND_MAX.
  typedef logic [$clog2(REGFILE_PEND_MAX + 1)-1:0] lc3b_pend_cnt;

  // Default geometry derived from the word and register-index types.
  localparam int REGFILE_WIDTH = $bits(lc3b_word);
  localparam int REGFILE_NREGS = 2 ** $bits(lc3b_reg);

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between decode/writeback (master) and the scoreboarded regfile (slave).
interface regfile_sb_if
  import lc3b_types::*;
#(
  parameter int WIDTH = REGFILE_WIDTH,
  parameter int NREGS = REGFILE_NREGS,
  parameter int NREAD = 2
);
  localparam int IDX_W = $clog2(NREGS);

  // Writeback side
  logic                            load;
  logic [IDX_W-1:0]                dest;
  logic [WIDTH-1:0]                in;
  // Decode read side
  logic [NREAD-1:0][IDX_W-1:0]     src;
  logic [NREAD-1:0][WIDTH-1:0]     reg_out;
  logic [NREAD-1:0]                reg_rdy;
  // Decode issue side
  logic                            issue_valid;
  logic [IDX_W-1:0]                issue_dest;
  logic                            issue_ready;
  // Status
  logic                            wb_err;

  modport master (
    output load, dest, in, src, issue_valid, issue_dest,
    input  reg_out, reg_rdy, issue_ready, wb_err
  );

  modport slave (
    input  load, dest, in, src, issue_valid, issue_dest,
    output reg_out, reg_rdy, issue_ready, wb_err
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters: issue increments, writeback retires,
// a same-cycle issue and retire to one register cancel out. Also produces
// issue_ready, the sticky spurious-writeback flag and per-read-port ready.
module regfile_scoreboard
  import lc3b_types::*;
#(
  parameter int NREGS    = REGFILE_NREGS,
  parameter int NREAD    = 2,
  parameter int PEND_MAX = REGFILE_PEND_MAX,
  parameter bit BYPASS   = 1'b0,
  localparam int IDX_W   = $clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [IDX_W-1:0]            dest,
  input  logic                        issue_valid,
  input  logic [IDX_W-1:0]            issue_dest,
  input  logic [NREAD-1:0][IDX_W-1:0] src,
  output logic                        issue_ready,
  output logic                        wb_err,
  output logic [NREAD-1:0]            port_rdy
);

  localparam int PW = $clog2(PEND_MAX + 1);
  localparam logic [PW-1:0] PEND_MAX_C = PW'(PEND_MAX);

  logic [PW-1:0] pend_q [NREGS];
  logic [PW-1:0] pend_d [NREGS];
  logic          wb_err_q;
  logic          wb_err_d;
  logic          issue_acc;

  // A retire in the same cycle frees the slot the new issue needs.
  always_comb begin
    issue_ready = (pend_q[issue_dest] < PEND_MAX_C) || (load && (dest == issue_dest));
    issue_acc   = issue_valid && issue_ready;
  end

  // Next counter values and sticky error; issue+retire to one register cancel.
  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < NREGS; r++) begin
      if (issue_acc && (issue_dest == IDX_W'(r))) begin
        if (!(load && (dest == IDX_W'(r)))) begin
          pend_d[r] = pend_q[r] + PW'(1);
        end
      end else if (load && (dest == IDX_W'(r)) && (pend_q[r] != '0)) begin
        pend_d[r] = pend_q[r] - PW'(1);
      end
    end
    wb_err_d = wb_err_q ||
               (load && (pend_q[dest] == '0) && !(issue_acc && (issue_dest == dest)));
  end

  // Counter and error state, cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= '0;
      end
      wb_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign wb_err = wb_err_q;

  // Per-port readiness; with forwarding a retiring write counts as done.
  for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
    if (BYPASS) begin : g_byp
      assign port_rdy[gi] = (load && (dest == src[gi])) ? (pend_q[src[gi]] <= PW'(1))
                                                        : (pend_q[src[gi]] == '0);
    end else begin : g_nobyp
      assign port_rdy[gi] = (pend_q[src[gi]] == '0);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded LC-3b register file: data array, read muxes and optional
// writeback-to-decode forwarding. The pending-write bookkeeping lives in
// regfile_scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle
// writeback data (and readiness) to matching read ports.
module regfile_sb
  import lc3b_types::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int NREGS    = REGFILE_NREGS,
  parameter int NREAD    = 2,
  parameter int PEND_MAX = REGFILE_PEND_MAX
) (
  input  logic       clk,
  input  logic       reset,
  regfile_sb_if.slave bus
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [WIDTH-1:0]             data_q [NREGS];
  logic [WIDTH-1:0]             data_d [NREGS];
  logic [NREAD-1:0][WIDTH-1:0]  rd_data;
  logic [NREAD-1:0]             rd_rdy;

  // Writeback always lands, even when it is a spurious retire.
  always_comb begin
    data_d = data_q;
    if (bus.load) begin
      data_d[bus.dest] = bus.in;
    end
  end

  // Register storage, cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        data_q[r] <= '0;
      end
    end else begin
      data_q <= data_d;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NREAD    (NREAD),
    .PEND_MAX (PEND_MAX),
    .BYPASS   (BYPASS_EN)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .load        (bus.load),
    .dest        (bus.dest),
    .issue_valid (bus.issue_valid),
    .issue_dest  (bus.issue_dest),
    .src         (bus.src),
    .issue_ready (bus.issue_ready),
    .wb_err      (bus.wb_err),
    .port_rdy    (rd_rdy)
  );

  // Read muxes; every port may read any register simultaneously.
  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    if (BYPASS_EN) begin : g_byp
      assign rd_data[gi] = (bus.load && (bus.dest == bus.src[gi])) ? bus.in
                                                                  : data_q[bus.src[gi]];
    end else begin : g_nobyp
      assign rd_data[gi] = data_q[bus.src[gi]];
    end
  end

  assign bus.reg_out = rd_data;
  assign bus.reg_rdy = rd_rdy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (default geometry). Expected values are
// queued when stimulus is driven and popped when the output is sampled.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic reset;

  regfile_sb_if #(.WIDTH(16), .NREGS(8), .NREAD(2)) bus ();

  regfile_sb #(
    .WIDTH    (16),
    .NREGS    (8),
    .NREAD    (2),
    .PEND_MAX (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string       tag_q[$];
  logic [15:0] exp_q[$];

  task automatic sb_push(input string tag, input logic [15:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [15:0] obs);
    string       t;
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow observed %h required none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e)
      else begin
        errors++;
        $error("FAIL %s observed %h required %h", t, obs, e);
      end
      $display("check %-22s observed %h required %h", t, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [2:0] r);
    bus.issue_valid = 1'b1;
    bus.issue_dest  = r;
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic retire(input logic [2:0] r, input logic [15:0] d);
    bus.load = 1'b1;
    bus.dest = r;
    bus.in   = d;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    bus.load        = 1'b0;
    bus.dest        = '0;
    bus.in          = '0;
    bus.src         = '0;
    bus.issue_valid = 1'b0;
    bus.issue_dest  = '0;

    // Reset state
    #7;
    sb_push("rst_out0", 16'h0000);  check(bus.reg_out[0]);
    sb_push("rst_rdy", 16'h0003);   check(16'(bus.reg_rdy));
    sb_push("rst_ready", 16'h0001); check(16'(bus.issue_ready));
    sb_push("rst_wberr", 16'h0000); check(16'(bus.wb_err));
    #3 reset = 1'b0;
    tick();

    // Write R5 then read it back; other registers stay zero
    bus.src[0] = 3'd5;
    issue(3'd5);
    settle();
    sb_push("r5_pending", 16'h0000); check(16'(bus.reg_rdy[0]));
    sb_push("r5_data", 16'hBEEF);
    sb_push("r5_rdy", 16'h0001);
    retire(3'd5, 16'hBEEF);
    settle();
    check(bus.reg_out[0]);
    check(16'(bus.reg_rdy[0]));
    for (int r = 0; r < 8; r++) begin
      if (r != 5) begin
        bus.src[0] = 3'(r);
        settle();
        sb_push($sformatf("r%0d_zero", r), 16'h0000);
        check(bus.reg_out[0]);
      end
    end

    // Fill R2 to the limit; a fourth issue is ignored
    bus.src[0] = 3'd2;
    issue(3'd2); issue(3'd2); issue(3'd2);
    bus.issue_dest = 3'd2;
    settle();
    sb_push("r2_full_ready", 16'h0000); check(16'(bus.issue_ready));
    sb_push("r2_full_rdy", 16'h0000);   check(16'(bus.reg_rdy[0]));
    issue(3'd2);
    sb_push("r2_ld1_rdy", 16'h0000);
    sb_push("r2_ld1_ready", 16'h0001);
    retire(3'd2, 16'h1111);
    settle();
    check(16'(bus.reg_rdy[0]));
    check(16'(bus.issue_ready));
    sb_push("r2_ld2_rdy", 16'h0000);
    retire(3'd2, 16'h2222);
    settle();
    check(16'(bus.reg_rdy[0]));
    sb_push("r2_ld3_rdy", 16'h0001);
    sb_push("r2_ld3_data", 16'h3333);
    sb_push("r2_wberr", 16'h0000);
    retire(3'd2, 16'h3333);
    settle();
    check(16'(bus.reg_rdy[0]));
    check(bus.reg_out[0]);
    check(16'(bus.wb_err));

    // R4: issue and retire in the same cycle leaves the count alone
    bus.src[0] = 3'd4;
    issue(3'd4);
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 3'd4;
    bus.load        = 1'b1;
    bus.dest        = 3'd4;
    bus.in          = 16'h4444;
    sb_push("r4_same_rdy", 16'h0000);
    sb_push("r4_same_data", 16'h4444);
    tick();
    bus.issue_valid = 1'b0;
    bus.load        = 1'b0;
    settle();
    check(16'(bus.reg_rdy[0]));
    check(bus.reg_out[0]);
    sb_push("r4_drain_rdy", 16'h0001);
    sb_push("r4_drain_wberr", 16'h0000);
    retire(3'd4, 16'h4545);
    settle();
    check(16'(bus.reg_rdy[0]));
    check(16'(bus.wb_err));

    // R4 at the limit: a same-cycle retire lets the issue through
    issue(3'd4); issue(3'd4); issue(3'd4);
    bus.issue_dest = 3'd4;
    settle();
    sb_push("r4_max_ready", 16'h0000); check(16'(bus.issue_ready));
    bus.load        = 1'b1;
    bus.dest        = 3'd4;
    bus.in          = 16'h4646;
    bus.issue_valid = 1'b1;
    settle();
    sb_push("r4_max_ld_ready", 16'h0001); check(16'(bus.issue_ready));
    sb_push("r4_max_after", 16'h0000);
    sb_push("r4_max_data", 16'h4646);
    tick();
    bus.load        = 1'b0;
    bus.issue_valid = 1'b0;
    settle();
    check(16'(bus.issue_ready));
    check(bus.reg_out[0]);
    retire(3'd4, 16'h4747);
    retire(3'd4, 16'h4848);
    sb_push("r4_max_drain_rdy", 16'h0000);
    settle();
    check(16'(bus.reg_rdy[0]));
    sb_push("r4_max_empty_rdy", 16'h0001);
    sb_push("r4_max_wberr", 16'h0000);
    retire(3'd4, 16'h4949);
    settle();
    check(16'(bus.reg_rdy[0]));
    check(16'(bus.wb_err));

    // R1 retire observed in the writeback cycle
    issue(3'd1);
    bus.src[1] = 3'd1;
    bus.load   = 1'b1;
    bus.dest   = 3'd1;
    bus.in     = 16'h00A5;
    settle();
`ifdef REGFILE_BYPASS_EN
    sb_push("byp_data", 16'h00A5);
    sb_push("byp_rdy", 16'h0001);
`else
    sb_push("byp_data", 16'h0000);
    sb_push("byp_rdy", 16'h0000);
`endif
    check(bus.reg_out[1]);
    check(16'(bus.reg_rdy[1]));
    tick();
    bus.load = 1'b0;
    settle();
    sb_push("byp_after_data", 16'h00A5); check(bus.reg_out[1]);
    sb_push("byp_after_rdy", 16'h0001);  check(16'(bus.reg_rdy[1]));
    sb_push("byp_wberr", 16'h0000);      check(16'(bus.wb_err));

    // Spurious writeback to R6
    sb_push("spur_data", 16'h6666);
    sb_push("spur_wberr", 16'h0001);
    retire(3'd6, 16'h6666);
    bus.src[0] = 3'd6;
    settle();
    check(bus.reg_out[0]);
    check(16'(bus.wb_err));
    tick(); tick(); tick();
    sb_push("spur_wberr_hold", 16'h0001); check(16'(bus.wb_err));

    // Mid-run reset with R3=1234 and two writes pending
    issue(3'd3);
    retire(3'd3, 16'h1234);
    issue(3'd3);
    issue(3'd3);
    bus.src[0]     = 3'd3;
    bus.src[1]     = 3'd3;
    bus.issue_dest = 3'd3;
    settle();
    sb_push("pre_rst_data", 16'h1234); check(bus.reg_out[0]);
    sb_push("pre_rst_rdy", 16'h0000);  check(16'(bus.reg_rdy));
    reset = 1'b1;
    #1;
    sb_push("mid_rst_out0", 16'h0000);  check(bus.reg_out[0]);
    sb_push("mid_rst_out1", 16'h0000);  check(bus.reg_out[1]);
    sb_push("mid_rst_rdy", 16'h0003);   check(16'(bus.reg_rdy));
    sb_push("mid_rst_ready", 16'h0001); check(16'(bus.issue_ready));
    sb_push("mid_rst_wberr", 16'h0000); check(16'(bus.wb_err));
    #2 reset = 1'b0;
    tick();
    bus.src[0] = 3'd5;
    settle();
    sb_push("post_rst_r5", 16'h0000); check(bus.reg_out[0]);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed %0d required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, scoreboarded register file for the pipelined LC-3b datapath; the successor to the single-write, two-read regfile. It has a configurable width, register count and read-port count. A per-register pending-write counter lets decode stall on RAW hazards, and writeback clears it. Sits between decode (read/issue side) and writeback (write side).

## Interface
- WIDTH, 16, data word width in bits
- NREGS, 8, number of architectural registers (power of two, ≥2)
- NREAD, 2, number of independent read ports
- PEND_MAX, 3, maximum outstanding writes tracked per register (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- load  in  1  writeback enable
- dest  in  IDX_W  writeback register index, IDX_W = $clog2(NREGS)
- in  in  WIDTH  writeback data
- src  in  NREAD×IDX_W  read indices, packed array
- reg_out  out  NREAD×WIDTH  read data, combinational from src
- reg_rdy  out  NREAD  read port has no pending write
- issue_valid  in  1  decode requests to mark issue_dest pending
- issue_dest  in  IDX_W  register to be written by the issuing instruction
- issue_ready  out  1  issue_dest counter below PEND_MAX
- wb_err  out  1  sticky: writeback to a register with zero pending count

## Operation
- Data array: NREGS × WIDTH. On load, data[dest] <= in at the clock edge.
- Pending counter: pend[r], width $clog2(PEND_MAX+1), one per register.
- Issue accepted when issue_valid && issue_ready; accepted issue increments pend[issue_dest].
- load decrements pend[dest] when pend[dest] > 0.
- Accepted issue and load to the same register in one cycle: counter unchanged.
- load with pend[dest] == 0 (and no simultaneous issue to dest): data is written, counter stays 0, wb_err sets and holds until reset.
- issue_ready = (pend[issue_dest] < PEND_MAX) || (load && dest == issue_dest). A simultaneous retire frees a slot.
- reg_out[i] = data[src[i]]. reg_rdy[i] = (pend[src[i]] == 0), subject to bypass (see Configuration).
- Reads of any index are legal on every port at the same time. There are no read collisions.

## Timing
- Reset (async assert): all data words 0, all pend 0, wb_err 0. Outputs are therefore reg_out = 0, reg_rdy all 1, issue_ready 1.
- Reset deassertion is synchronised by the integrator. No partial-state requirement applies mid-operation; assertion clears everything immediately.
- Write latency: data is visible on reg_out in the cycle after the load edge (without bypass).
- Issue-to-stall latency: a pending mark is visible on reg_rdy in the cycle after the accepted issue.
- Counter saturation: it never exceeds PEND_MAX, because issue_ready blocks the increment. Issue while not ready is ignored, with no state change.

## Configuration
- REGFILE_BYPASS_EN defined: when load && dest == src[i], reg_out[i] = in. reg_rdy[i] = 1 if pend[src[i]] ≤ 1 in that case. Same-cycle writeback forwards to decode.
- Undefined: no forwarding. A read in the writeback cycle returns old data, and reg_rdy reflects the pre-edge count.

## Structure
- lc3b_types keeps lc3b_word and lc3b_reg for default instantiation.
- Add to lc3b_types: REGFILE_PEND_MAX constant, and a pend-count typedef for the default configuration.
- One sub-module, regfile_scoreboard: owns the pend counters, issue_ready, wb_err and the per-port pending lookups.
- regfile_sb holds the data array, read muxes and bypass logic.

## Test plan
- Reset check: assert reset mid-run after writing R3=16'h1234 with pend[R3]=2. Required response, immediately: reg_out=0, reg_rdy=1, issue_ready=1, wb_err=0.
- Write then read: load R5=16'hBEEF, src[0]=5. Required response: reg_out[0]=16'hBEEF in the next cycle, and R0–R4, R6, R7 remain 0.
- Scoreboard: issue R2 three times (PEND_MAX=3). Required response: issue_ready=0 for R2, and a fourth issue is ignored. Then one load to R2 gives pend 2, with reg_rdy still 0. After three loads total, reg_rdy=1.
- Simultaneous issue and load to R4 with pend=1: pend stays 1 and data is updated. Issue to R4 at PEND_MAX with a same-cycle load is accepted.
- Spurious writeback: load R6 with pend 0. Required response: data written, wb_err=1, and it stays set until reset.
- Bypass: with REGFILE_BYPASS_EN, pend[R1]=1, load R1=16'h00A5, src[1]=1. Required response: same-cycle reg_out[1]=16'h00A5 and reg_rdy[1]=1. Without the macro: old data and reg_rdy[1]=0.
